// File: rtl/mem_axi_txn_limiter.sv
// Per-channel AXI4 outstanding-transaction limiter: zero-latency pass-through, AW/AR throttled at MAX_*_OUT.
// Optional per-direction watchdog built when MEM_TXN_WATCHDOG_EN is defined; otherwise timeouts tie to 0.
module mem_axi_txn_limiter #(
  parameter int DATA_W         = 512,
  parameter int ADDR_W         = 32,
  parameter int ID_W           = 9,
  parameter int USER_W         = 1,
  parameter int LEN_W          = 8,
  parameter int MAX_WR_OUT     = 64,
  parameter int MAX_RD_OUT     = 64,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ID_W-1:0]     s_awid,
  input  logic [ADDR_W-1:0]   s_awaddr,
  input  logic [LEN_W-1:0]    s_awlen,
  input  logic [2:0]          s_awsize,
  input  logic [1:0]          s_awburst,
  input  logic [USER_W-1:0]   s_awuser,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_wlast,
  input  logic [USER_W-1:0]   s_wuser,
  input  logic                s_wvalid,
  output logic                s_wready,
  output logic [ID_W-1:0]     s_bid,
  output logic [1:0]          s_bresp,
  output logic                s_bvalid,
  input  logic                s_bready,
  input  logic [ID_W-1:0]     s_arid,
  input  logic [ADDR_W-1:0]   s_araddr,
  input  logic [LEN_W-1:0]    s_arlen,
  input  logic [2:0]          s_arsize,
  input  logic [1:0]          s_arburst,
  input  logic [USER_W-1:0]   s_aruser,
  input  logic                s_arvalid,
  output logic                s_arready,
  output logic [ID_W-1:0]     s_rid,
  output logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          s_rresp,
  output logic                s_rlast,
  output logic                s_rvalid,
  input  logic                s_rready,
  output logic [ID_W-1:0]     m_awid,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [LEN_W-1:0]    m_awlen,
  output logic [2:0]          m_awsize,
  output logic [1:0]          m_awburst,
  output logic [USER_W-1:0]   m_awuser,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wlast,
  output logic [USER_W-1:0]   m_wuser,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [ID_W-1:0]     m_bid,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready,
  output logic [ID_W-1:0]     m_arid,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [LEN_W-1:0]    m_arlen,
  output logic [2:0]          m_arsize,
  output logic [1:0]          m_arburst,
  output logic [USER_W-1:0]   m_aruser,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [ID_W-1:0]     m_rid,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rlast,
  input  logic                m_rvalid,
  output logic                m_rready,
  input  logic                err_clr,
  output logic [7:0]          wr_outstanding,
  output logic [7:0]          rd_outstanding,
  output logic                idle,
  output logic                err_wr_unexp,
  output logic                err_rd_unexp,
  output logic                wr_timeout,
  output logic                rd_timeout
);

  logic [7:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic       wr_full, rd_full, aw_hs, b_hs, ar_hs, rl_hs;
  logic       wr_unexp_ev, rd_unexp_ev, err_wr_q, err_rd_q;

  assign wr_full = (wr_cnt_q == 8'(MAX_WR_OUT));
  assign rd_full = (rd_cnt_q == 8'(MAX_RD_OUT));

  assign m_awid = s_awid;  assign m_awaddr = s_awaddr;  assign m_awlen = s_awlen;
  assign m_awsize = s_awsize;  assign m_awburst = s_awburst;  assign m_awuser = s_awuser;
  assign m_awvalid = s_awvalid & ~wr_full;
  assign s_awready = m_awready & ~wr_full;

  assign m_wdata = s_wdata;  assign m_wstrb = s_wstrb;  assign m_wlast = s_wlast;
  assign m_wuser = s_wuser;  assign m_wvalid = s_wvalid;  assign s_wready = m_wready;

  assign s_bid = m_bid;  assign s_bresp = m_bresp;  assign s_bvalid = m_bvalid;
  assign m_bready = s_bready;

  assign m_arid = s_arid;  assign m_araddr = s_araddr;  assign m_arlen = s_arlen;
  assign m_arsize = s_arsize;  assign m_arburst = s_arburst;  assign m_aruser = s_aruser;
  assign m_arvalid = s_arvalid & ~rd_full;
  assign s_arready = m_arready & ~rd_full;

  assign s_rid = m_rid;  assign s_rdata = m_rdata;  assign s_rresp = m_rresp;
  assign s_rlast = m_rlast;  assign s_rvalid = m_rvalid;  assign m_rready = s_rready;

  assign aw_hs = m_awvalid & m_awready;
  assign b_hs  = m_bvalid & s_bready;
  assign ar_hs = m_arvalid & m_arready;
  assign rl_hs = m_rvalid & s_rready & m_rlast;

  // A lone decrement at zero saturates and is flagged; inc+dec together is always net zero.
  always_comb begin
    wr_cnt_d    = wr_cnt_q;
    wr_unexp_ev = 1'b0;
    if (aw_hs && !b_hs) begin
      wr_cnt_d = wr_cnt_q + 8'd1;
    end else if (!aw_hs && b_hs) begin
      if (wr_cnt_q == 8'd0) wr_unexp_ev = 1'b1;
      else                  wr_cnt_d = wr_cnt_q - 8'd1;
    end
    rd_cnt_d    = rd_cnt_q;
    rd_unexp_ev = 1'b0;
    if (ar_hs && !rl_hs) begin
      rd_cnt_d = rd_cnt_q + 8'd1;
    end else if (!ar_hs && rl_hs) begin
      if (rd_cnt_q == 8'd0) rd_unexp_ev = 1'b1;
      else                  rd_cnt_d = rd_cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt_q <= 8'd0;
      rd_cnt_q <= 8'd0;
      err_wr_q <= 1'b0;
      err_rd_q <= 1'b0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      err_wr_q <= (err_wr_q & ~err_clr) | wr_unexp_ev;
      err_rd_q <= (err_rd_q & ~err_clr) | rd_unexp_ev;
    end
  end

  assign wr_outstanding = wr_cnt_q;
  assign rd_outstanding = rd_cnt_q;
  assign idle           = (wr_cnt_q == 8'd0) && (rd_cnt_q == 8'd0);
  assign err_wr_unexp   = err_wr_q;
  assign err_rd_unexp   = err_rd_q;

`ifdef MEM_TXN_WATCHDOG_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {WD_IDLE, WD_ARMED, WD_EXPIRED} wd_state_e;

  logic [1:0] wd_nz, wd_rsp, wd_to;
  // Index 0 watches writes, index 1 reads; any R beat counts as read progress.
  assign wd_nz  = {rd_cnt_q != 8'd0, wr_cnt_q != 8'd0};
  assign wd_rsp = {m_rvalid & s_rready, b_hs};

  for (genvar g = 0; g < 2; g++) begin : g_wd
    wd_state_e      state_q;
    logic [TW-1:0]  timer_q;
    logic           to_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= WD_IDLE;
        timer_q <= '0;
        to_q    <= 1'b0;
      end else begin
        if (err_clr) to_q <= 1'b0;
        case (state_q)
          WD_IDLE: begin
            timer_q <= '0;
            if (wd_nz[g]) begin
              state_q <= WD_ARMED;
              timer_q <= wd_rsp[g] ? TW'(0) : TW'(1);
            end
          end
          WD_ARMED: begin
            if (!wd_nz[g]) begin
              state_q <= WD_IDLE;
              timer_q <= '0;
            end else if (wd_rsp[g]) begin
              timer_q <= '0;
            end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
              state_q <= WD_EXPIRED;
              timer_q <= '0;
              to_q    <= 1'b1;
            end else begin
              timer_q <= timer_q + TW'(1);
            end
          end
          default: begin
            timer_q <= '0;
            if (!wd_nz[g])      state_q <= WD_IDLE;
            else if (wd_rsp[g]) state_q <= WD_ARMED;
          end
        endcase
      end
    end

    assign wd_to[g] = to_q;
  end

  assign wr_timeout = wd_to[0];
  assign rd_timeout = wd_to[1];
`else
  assign wr_timeout = 1'b0;
  assign rd_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mem_axi_txn_limiter.sv
// Directed self-checking bench for mem_axi_txn_limiter (MAX_WR_OUT=8, MAX_RD_OUT=4, TIMEOUT_CYCLES=16).
module tb_mem_axi_txn_limiter;
  localparam int DW = 32, AW = 32, IW = 9, UW = 1, LW = 8;
`ifdef MEM_TXN_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [IW-1:0] s_awid, s_arid, s_bid, s_rid, m_awid, m_arid, m_bid, m_rid;
  logic [AW-1:0] s_awaddr, s_araddr, m_awaddr, m_araddr;
  logic [LW-1:0] s_awlen, s_arlen, m_awlen, m_arlen;
  logic [2:0]    s_awsize, s_arsize, m_awsize, m_arsize;
  logic [1:0]    s_awburst, s_arburst, m_awburst, m_arburst;
  logic [UW-1:0] s_awuser, s_aruser, s_wuser, m_awuser, m_aruser, m_wuser;
  logic [DW-1:0] s_wdata, m_wdata, s_rdata, m_rdata;
  logic [DW/8-1:0] s_wstrb, m_wstrb;
  logic [1:0]    s_bresp, m_bresp, s_rresp, m_rresp;
  logic s_awvalid, s_awready, s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;
  logic s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
  logic m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;
  logic m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
  logic err_clr, idle, err_wr_unexp, err_rd_unexp, wr_timeout, rd_timeout;
  logic [7:0] wr_outstanding, rd_outstanding;

  int checks = 0;
  int failures = 0;

  mem_axi_txn_limiter #(
    .DATA_W(DW), .ADDR_W(AW), .ID_W(IW), .USER_W(UW), .LEN_W(LW),
    .MAX_WR_OUT(8), .MAX_RD_OUT(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awuser(s_awuser), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wuser(s_wuser),
    .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_aruser(s_aruser), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awuser(m_awuser), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wuser(m_wuser),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_aruser(m_aruser), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .err_clr(err_clr), .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding),
    .idle(idle), .err_wr_unexp(err_wr_unexp), .err_rd_unexp(err_rd_unexp),
    .wr_timeout(wr_timeout), .rd_timeout(rd_timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_errors();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++; if (wr_outstanding !== 8'd0) begin failures++; $display("FAIL reset_wr_cnt got=%0d exp=0", wr_outstanding); end
    checks++; if (rd_outstanding !== 8'd0) begin failures++; $display("FAIL reset_rd_cnt got=%0d exp=0", rd_outstanding); end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL reset_idle got=%b exp=1", idle); end
    checks++; if ({err_wr_unexp, err_rd_unexp, wr_timeout, rd_timeout} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags got=%b exp=0000", {err_wr_unexp, err_rd_unexp, wr_timeout, rd_timeout});
    end
    s_awaddr = 32'h1234_5678; s_awid = 9'h1A5; s_awvalid = 1'b1;
    #1;
    checks++; if ({m_awvalid, s_awready} !== 2'b11) begin failures++; $display("FAIL reset_aw_pass got=%b exp=11", {m_awvalid, s_awready}); end
    checks++; if (m_awaddr !== 32'h1234_5678 || m_awid !== 9'h1A5) begin
      failures++; $display("FAIL aw_payload got=%h/%h exp=12345678/1a5", m_awaddr, m_awid);
    end
    m_awready = 1'b0;
    #1;
    checks++; if (s_awready !== 1'b0) begin failures++; $display("FAIL aw_ready_follow got=%b exp=0", s_awready); end
    s_awvalid = 1'b0; m_awready = 1'b1;
    s_araddr = 32'h0BAD_F00D; s_arvalid = 1'b1;
    s_wdata = 32'hDEAD_BEEF; m_bresp = 2'b10; m_rdata = 32'hCAFE_F00D; m_wready = 1'b1; s_bready = 1'b1;
    #1;
    checks++; if (m_araddr !== 32'h0BAD_F00D || m_arvalid !== 1'b1) begin
      failures++; $display("FAIL ar_pass got=%h/%b exp=0badf00d/1", m_araddr, m_arvalid);
    end
    checks++; if (m_wdata !== 32'hDEAD_BEEF || s_rdata !== 32'hCAFE_F00D || s_bresp !== 2'b10) begin
      failures++; $display("FAIL data_pass got=%h/%h/%b exp=deadbeef/cafef00d/10", m_wdata, s_rdata, s_bresp);
    end
    checks++; if ({s_wready, m_bready} !== 2'b11) begin failures++; $display("FAIL ready_pass got=%b exp=11", {s_wready, m_bready}); end
    s_arvalid = 1'b0; m_wready = 1'b0; s_bready = 1'b0;
  endtask

  task automatic test_rd_throttle();
    s_arvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (s_arready !== (i < 4)) begin failures++; $display("FAIL thr_arready[%0d] got=%b exp=%b", i, s_arready, i < 4); end
      tick();
    end
    checks++; if (rd_outstanding !== 8'd4) begin failures++; $display("FAIL thr_cnt got=%0d exp=4", rd_outstanding); end
    checks++; if (m_arvalid !== 1'b0 || idle !== 1'b0) begin failures++; $display("FAIL thr_block got=%b/%b exp=0/0", m_arvalid, idle); end
    m_rvalid = 1'b1; m_rlast = 1'b1; s_rready = 1'b1;
    #1;
    checks++; if (s_arready !== 1'b0) begin failures++; $display("FAIL thr_same_cycle got=%b exp=0", s_arready); end
    tick();
    m_rvalid = 1'b0;
    checks++; if (s_arready !== 1'b1 || rd_outstanding !== 8'd3) begin
      failures++; $display("FAIL thr_release got=%b/%0d exp=1/3", s_arready, rd_outstanding);
    end
    tick();
    s_arvalid = 1'b0;
    checks++; if (rd_outstanding !== 8'd4) begin failures++; $display("FAIL thr_fifth got=%0d exp=4", rd_outstanding); end
    m_rvalid = 1'b1; m_rlast = 1'b0;
    tick();
    m_rlast = 1'b1; s_rready = 1'b0;
    tick();
    checks++; if (rd_outstanding !== 8'd4) begin failures++; $display("FAIL thr_nonlast got=%0d exp=4", rd_outstanding); end
    s_rready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    checks++; if (rd_outstanding !== 8'd0 || idle !== 1'b1 || err_rd_unexp !== 1'b0) begin
      failures++; $display("FAIL thr_drain got=%0d/%b/%b exp=0/1/0", rd_outstanding, idle, err_rd_unexp);
    end
  endtask

  task automatic test_simultaneous();
    s_awvalid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks++; if (wr_outstanding !== 8'd3) begin failures++; $display("FAIL sim_pre got=%0d exp=3", wr_outstanding); end
    m_bvalid = 1'b1; s_bready = 1'b1;
    tick();
    checks++; if (wr_outstanding !== 8'd3 || err_wr_unexp !== 1'b0) begin
      failures++; $display("FAIL sim_incdec got=%0d/%b exp=3/0", wr_outstanding, err_wr_unexp);
    end
    s_awvalid = 1'b0;
    tick();
    checks++; if (wr_outstanding !== 8'd2) begin failures++; $display("FAIL sim_dec got=%0d exp=2", wr_outstanding); end
    tick(); tick();
    m_bvalid = 1'b0;
    s_arvalid = 1'b1; m_rvalid = 1'b1; m_rlast = 1'b1; s_rready = 1'b1;
    tick();
    s_arvalid = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0;
    checks++; if (rd_outstanding !== 8'd0 || err_rd_unexp !== 1'b0 || wr_outstanding !== 8'd0) begin
      failures++; $display("FAIL sim_zero got=%0d/%b/%0d exp=0/0/0", rd_outstanding, err_rd_unexp, wr_outstanding);
    end
    s_awvalid = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    checks++; if (wr_outstanding !== 8'd8 || s_awready !== 1'b0 || m_awvalid !== 1'b0) begin
      failures++; $display("FAIL wr_full got=%0d/%b/%b exp=8/0/0", wr_outstanding, s_awready, m_awvalid);
    end
    s_awvalid = 1'b0; m_bvalid = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    m_bvalid = 1'b0;
    checks++; if (wr_outstanding !== 8'd0 || err_wr_unexp !== 1'b0) begin
      failures++; $display("FAIL wr_drain got=%0d/%b exp=0/0", wr_outstanding, err_wr_unexp);
    end
  endtask

  task automatic test_underflow();
    m_bvalid = 1'b1; s_bready = 1'b1;
    tick();
    m_bvalid = 1'b0;
    checks++; if (err_wr_unexp !== 1'b1 || wr_outstanding !== 8'd0 || err_rd_unexp !== 1'b0) begin
      failures++; $display("FAIL uf_wr got=%b/%0d/%b exp=1/0/0", err_wr_unexp, wr_outstanding, err_rd_unexp);
    end
    m_rvalid = 1'b1; m_rlast = 1'b1; s_rready = 1'b1;
    tick();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    checks++; if (err_rd_unexp !== 1'b1 || rd_outstanding !== 8'd0) begin
      failures++; $display("FAIL uf_rd got=%b/%0d exp=1/0", err_rd_unexp, rd_outstanding);
    end
    tick();
    checks++; if (err_wr_unexp !== 1'b1) begin failures++; $display("FAIL uf_sticky got=%b exp=1", err_wr_unexp); end
    clear_errors();
    checks++; if ({err_wr_unexp, err_rd_unexp} !== 2'b00) begin failures++; $display("FAIL uf_clear got=%b exp=00", {err_wr_unexp, err_rd_unexp}); end
    err_clr = 1'b1; m_bvalid = 1'b1;
    tick();
    err_clr = 1'b0; m_bvalid = 1'b0;
    checks++; if (err_wr_unexp !== 1'b1) begin failures++; $display("FAIL uf_set_wins got=%b exp=1", err_wr_unexp); end
    clear_errors();
    checks++; if (err_wr_unexp !== 1'b0) begin failures++; $display("FAIL uf_clear2 got=%b exp=0", err_wr_unexp); end
  endtask

  task automatic test_watchdog();
    clear_errors();
    s_arvalid = 1'b1;
    tick();
    s_arvalid = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      tick();
      checks++; if (rd_timeout !== (WD && k >= 16)) begin failures++; $display("FAIL wd_rd_single[%0d] got=%b exp=%b", k, rd_timeout, WD && k >= 16); end
    end
    m_rvalid = 1'b1; m_rlast = 1'b1; s_rready = 1'b1;
    tick();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    clear_errors();
    checks++; if (rd_timeout !== 1'b0 || rd_outstanding !== 8'd0) begin
      failures++; $display("FAIL wd_clear got=%b/%0d exp=0/0", rd_timeout, rd_outstanding);
    end
    s_arvalid = 1'b1;
    tick();
    s_arvalid = 1'b0;
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 9; j++) tick();
      m_rvalid = 1'b1;
      tick();
      m_rvalid = 1'b0;
      checks++; if (rd_timeout !== 1'b0) begin failures++; $display("FAIL wd_periodic[%0d] got=%b exp=0", r, rd_timeout); end
    end
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 15) begin
        checks++; if (rd_timeout !== 1'b0) begin failures++; $display("FAIL wd_after_beat15 got=%b exp=0", rd_timeout); end
      end
      if (k == 16) begin
        checks++; if (rd_timeout !== WD) begin failures++; $display("FAIL wd_after_beat16 got=%b exp=%b", rd_timeout, WD); end
      end
    end
    m_rvalid = 1'b1; m_rlast = 1'b1;
    tick();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    clear_errors();
    checks++; if (wr_timeout !== 1'b0) begin failures++; $display("FAIL wd_wr_quiet got=%b exp=0", wr_timeout); end
    s_awvalid = 1'b1;
    tick();
    s_awvalid = 1'b0;
    for (int k = 1; k <= 16; k++) tick();
    checks++; if (wr_timeout !== WD || rd_timeout !== 1'b0) begin
      failures++; $display("FAIL wd_wr_single got=%b/%b exp=%b/0", wr_timeout, rd_timeout, WD);
    end
    m_bvalid = 1'b1;
    tick();
    m_bvalid = 1'b0;
    clear_errors();
    checks++; if (wr_timeout !== 1'b0 || idle !== 1'b1) begin
      failures++; $display("FAIL wd_end got=%b/%b exp=0/1", wr_timeout, idle);
    end
  endtask

  initial begin
    rst = 1'b1; err_clr = 1'b0;
    s_awid = '0; s_awaddr = '0; s_awlen = 8'd3; s_awsize = 3'd2; s_awburst = 2'b01; s_awuser = '0; s_awvalid = 1'b0;
    s_wdata = '0; s_wstrb = '1; s_wlast = 1'b0; s_wuser = '0; s_wvalid = 1'b0; s_bready = 1'b0;
    s_arid = '0; s_araddr = '0; s_arlen = 8'd0; s_arsize = 3'd2; s_arburst = 2'b01; s_aruser = '0; s_arvalid = 1'b0;
    s_rready = 1'b0;
    m_awready = 1'b1; m_wready = 1'b0; m_bid = '0; m_bresp = '0; m_bvalid = 1'b0;
    m_arready = 1'b1; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
    test_reset();
    test_rd_throttle();
    test_simultaneous();
    test_underflow();
    test_watchdog();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
